// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD write controller.
// CPU words are queued in a 4-entry FIFO and replayed onto the panel bus
// with setup / enable / hold / settle timing. A fixed power-on init
// sequence runs after every reset before any queued word is sent.
module lcd_ctrl #(
  parameter int POWERUP_CYC   = 750000,
  parameter int SETUP_CYC     = 2,
  parameter int EN_CYC        = 12,
  parameter int HOLD_CYC      = 2,
  parameter int WAIT_CYC      = 2000,
  parameter int LONG_WAIT_CYC = 82000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_wdata,
  input  logic        i_lcd_we,
  input  logic        i_clr_ovf,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic        o_init_done,
  output logic        o_fifo_full,
  output logic        o_overflow
);

  // One shared down-counter is sized for the longest interval it must hold.
  localparam int MAX_A   = (POWERUP_CYC > LONG_WAIT_CYC) ? POWERUP_CYC : LONG_WAIT_CYC;
  localparam int MAX_B   = (WAIT_CYC > EN_CYC) ? WAIT_CYC : EN_CYC;
  localparam int MAX_C   = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_MAX = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_INIT_LOAD,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  // FIFO entry layout: {ON, RS, byte}
  typedef logic [9:0] entry_t;

  // Power-on command list: function set, display on, clear, entry mode.
  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [1:0]         init_idx;
  logic               load_pins;
  entry_t             pin_word;
  logic               en_d;
  logic               adv_init;
  logic               set_done;
  logic               long_wait;

  entry_t             fifo_mem [4];
  logic [1:0]         wr_ptr, rd_ptr;
  logic [2:0]         count;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic               drop;
  entry_t             wr_entry;
  logic               unused_wdata;

  assign unused_wdata = ^i_lcd_wdata[30:9];
  assign wr_entry     = {i_lcd_wdata[31], i_lcd_wdata[8], i_lcd_wdata[7:0]};

  // A pop only happens from IDLE, which is unreachable until init finishes,
  // so words written during init stay queued.
  assign fifo_full = (count == 3'd4);
  assign pop       = (state == S_IDLE) && (count != 3'd0);
  assign push      = i_lcd_we && (!fifo_full || pop);
  assign drop      = i_lcd_we && fifo_full && !pop;

  // Clear/home commands need the long settle time.
  assign long_wait = !o_lcd_rs && (o_lcd_data inside {8'h01, 8'h02, 8'h03});

  // State and interval counter register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_reset) begin
      state <= S_INIT_WAIT;
      cnt   <= CNT_W'(POWERUP_CYC);
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state, counter reload and datapath control decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    state_d   = state;
    cnt_d     = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    load_pins = 1'b0;
    pin_word  = fifo_mem[rd_ptr];
    en_d      = 1'b0;
    adv_init  = 1'b0;
    set_done  = 1'b0;

    case (state)
      S_INIT_WAIT: begin
        if (cnt == '0) state_d = S_INIT_LOAD;
      end
      S_INIT_LOAD: begin
        load_pins = 1'b1;
        pin_word  = {1'b1, 1'b0, init_byte(init_idx)};
        state_d   = S_SETUP;
        cnt_d     = CNT_W'(SETUP_CYC);
      end
      S_IDLE: begin
        if (count != 3'd0) begin
          load_pins = 1'b1;
          state_d   = S_SETUP;
          cnt_d     = CNT_W'(SETUP_CYC);
        end
      end
      // The pins load on SETUP entry; EN rises SETUP_CYC cycles after the
      // bus has been presented for a full cycle.
      S_SETUP: begin
        if (cnt == '0) begin
          state_d = S_PULSE;
          cnt_d   = CNT_W'(EN_CYC - 1);
          en_d    = 1'b1;
        end
      end
      S_PULSE: begin
        en_d = 1'b1;
        if (cnt == '0) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          en_d    = 1'b0;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_d = S_WAIT;
          cnt_d   = long_wait ? CNT_W'(LONG_WAIT_CYC - 1) : CNT_W'(WAIT_CYC - 1);
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          if (o_init_done) begin
            state_d = S_IDLE;
          end else begin
            adv_init = 1'b1;
            if (init_idx == 2'd3) begin
              state_d  = S_IDLE;
              set_done = 1'b1;
            end else begin
              state_d = S_INIT_LOAD;
            end
          end
        end
      end
      default: begin
        state_d = S_INIT_WAIT;
      end
    endcase
  end

  // Registered panel pins, init progress and init-done flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_lcd_en    <= 1'b0;
      o_lcd_on    <= 1'b1;
      o_lcd_rs    <= 1'b0;
      o_lcd_data  <= 8'h00;
      init_idx    <= 2'd0;
      o_init_done <= 1'b0;
    end else begin
      o_lcd_en <= en_d;
      if (load_pins) {o_lcd_on, o_lcd_rs, o_lcd_data} <= pin_word;
      if (adv_init) init_idx <= init_idx + 2'd1;
      if (set_done) o_init_done <= 1'b1;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (drop)           o_overflow <= 1'b1;
      else if (i_clr_ovf) o_overflow <= 1'b0;
    end
  end

  // FIFO storage.
  always_ff @(posedge i_clk) begin
    // NOTE: storage has no reset; stale contents are unreachable once the
    // pointers and count are cleared, and it stays a plain RAM.
    if (push) fifo_mem[wr_ptr] <= wr_entry;
  end

  assign o_busy      = (state != S_IDLE) || (count != 3'd0);
  assign o_fifo_full = fifo_full;
  assign o_lcd_rw    = 1'b0;

endmodule
